run_controller: RTL and testbench

- Sequences the cellular-automaton core: owns the execution_enable line of the multiprocessor, which is tied high today.
- Accepts host commands RUN/STEP/STOP/CLEAR over a valid/ready handshake.
- Stops execution on a halt instruction, a PC breakpoint or a cycle budget, and reports status.
- Sits beside control, observing program_counter/instruction; drives a core-reset pulse into control and multiprocessor.

---
 rtl/run_controller.sv | 192 +++++++++++++++++++
 tb/tb_run_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// Run/step/stop sequencer for the cellular-automaton core: gates execution_enable and issues core resets.
// Optional trace outputs (trace_valid, trace_pc, halt_pc) are built when RUN_CTRL_TRACE_EN is defined.
module run_controller #(
  parameter int PC_WIDTH = 12,
  parameter int INSTR_WIDTH = 16,
  parameter logic [INSTR_WIDTH-1:0] HALT_INSTRUCTION = 16'hFFFF,
  parameter int CNT_WIDTH = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic                   breakpoint_en,
  input  logic [PC_WIDTH-1:0]    breakpoint_pc,
  input  logic [CNT_WIDTH-1:0]   cycle_limit,
  input  logic [PC_WIDTH-1:0]    program_counter,
  input  logic [INSTR_WIDTH-1:0] instruction,
  output logic                   execution_enable,
  output logic                   core_rst,
  output logic [1:0]             state,
  output logic [2:0]             halt_reason,
  output logic                   halt_done,
  output logic [CNT_WIDTH-1:0]   cycle_count,
  output logic                   trace_valid,
  output logic [PC_WIDTH-1:0]    trace_pc,
  output logic [PC_WIDTH-1:0]    halt_pc
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_HALTED = 3'd2;
  localparam logic [2:0] S_FLUSH  = 3'd3;
  localparam logic [2:0] S_STEP   = 3'd4;

  localparam logic [1:0] OP_RUN   = 2'd0;
  localparam logic [1:0] OP_STEP  = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [2:0] R_NONE  = 3'd0;
  localparam logic [2:0] R_HALT  = 3'd1;
  localparam logic [2:0] R_BREAK = 3'd2;
  localparam logic [2:0] R_LIMIT = 3'd3;
  localparam logic [2:0] R_HOST  = 3'd4;

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  logic [2:0]           state_reg, state_next;
  logic [2:0]           reason_reg, reason_next;
  logic [CNT_WIDTH-1:0] count_reg, count_next, count_inc;
  logic                 resume_reg, resume_next;
  logic                 halt_done_reg, halt_done_next;
  logic [FW-1:0]        flush_reg, flush_next;

  logic hi, bp, lim, accept;

  assign hi  = (instruction == HALT_INSTRUCTION);
  assign bp  = breakpoint_en && (program_counter == breakpoint_pc) && !resume_reg;
  assign lim = (cycle_limit != '0) && (count_reg >= cycle_limit);

  assign cmd_ready = (state_reg == S_IDLE) || (state_reg == S_RUN) || (state_reg == S_HALTED);
  assign accept    = cmd_valid && cmd_ready;

  // Combinational gate: the cycle a halt condition appears, the instruction is not executed.
  assign execution_enable = ((state_reg == S_RUN) && !hi && !bp && !lim) ||
                            ((state_reg == S_STEP) && !hi);

  assign count_inc = (count_reg == '1) ? count_reg : count_reg + 1'b1;

  always_comb begin
    state_next  = state_reg;
    reason_next = reason_reg;
    count_next  = count_reg;
    resume_next = resume_reg;
    flush_next  = flush_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_RUN:   begin state_next = S_RUN;  count_next = '0; resume_next = 1'b0; end
            OP_STEP:  begin state_next = S_STEP; count_next = '0; resume_next = 1'b0; end
            OP_CLEAR: state_next = S_FLUSH;
            default:  state_next = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        resume_next = 1'b0;
        if (execution_enable) count_next = count_inc;
        // A host CLEAR takes precedence over any halt condition seen in the same cycle.
        if (accept && cmd_op == OP_CLEAR) begin
          state_next = S_FLUSH;
        end else if (hi) begin
          state_next = S_HALTED; reason_next = R_HALT;
        end else if (bp) begin
          state_next = S_HALTED; reason_next = R_BREAK;
        end else if (lim) begin
          state_next = S_HALTED; reason_next = R_LIMIT;
        end else if (accept && cmd_op == OP_STOP) begin
          state_next = S_HALTED; reason_next = R_HOST;
        end
      end
      S_STEP: begin
        resume_next = 1'b0;
        state_next  = S_HALTED;
        if (hi) begin
          reason_next = R_HALT;
        end else begin
          reason_next = R_NONE;
          count_next  = count_inc;
        end
      end
      S_HALTED: begin
        if (accept) begin
          case (cmd_op)
            OP_RUN:   begin state_next = S_RUN;  resume_next = 1'b1; end
            OP_STEP:  begin state_next = S_STEP; resume_next = 1'b1; end
            OP_CLEAR: state_next = S_FLUSH;
            default:  state_next = S_HALTED;
          endcase
        end
      end
      S_FLUSH: begin
        if (flush_reg == '0) state_next = S_IDLE;
        else                 flush_next = flush_reg - 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
    if (state_next == S_FLUSH && state_reg != S_FLUSH) begin
      flush_next  = FLUSH_LAST;
      count_next  = '0;
      reason_next = R_NONE;
      resume_next = 1'b0;
    end
  end

  assign halt_done_next = (state_next == S_HALTED) && (state_reg != S_HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      reason_reg    <= R_NONE;
      count_reg     <= '0;
      resume_reg    <= 1'b0;
      halt_done_reg <= 1'b0;
      flush_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      reason_reg    <= reason_next;
      count_reg     <= count_next;
      resume_reg    <= resume_next;
      halt_done_reg <= halt_done_next;
      flush_reg     <= flush_next;
    end
  end

  assign core_rst    = (state_reg == S_FLUSH);
  assign state       = (state_reg == S_STEP) ? 2'd1 : state_reg[1:0];
  assign halt_reason = reason_reg;
  assign halt_done   = halt_done_reg;
  assign cycle_count = count_reg;

`ifdef RUN_CTRL_TRACE_EN
  logic                trace_valid_reg;
  logic [PC_WIDTH-1:0] trace_pc_reg;
  logic [PC_WIDTH-1:0] halt_pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      trace_valid_reg <= 1'b0;
      trace_pc_reg    <= '0;
      halt_pc_reg     <= '0;
    end else begin
      trace_valid_reg <= execution_enable;
      trace_pc_reg    <= program_counter;
      if (halt_done_next) halt_pc_reg <= program_counter;
    end
  end

  assign trace_valid = trace_valid_reg;
  assign trace_pc    = trace_pc_reg;
  assign halt_pc     = halt_pc_reg;
`else
  assign trace_valid = 1'b0;
  assign trace_pc    = '0;
  assign halt_pc     = '0;
`endif

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: run, halt instruction, breakpoint/resume, limit, step, stop, clear, reset.
module tb_run_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        breakpoint_en;
  logic [11:0] breakpoint_pc;
  logic [31:0] cycle_limit;
  logic [11:0] program_counter;
  logic [15:0] instruction;
  logic        execution_enable;
  logic        core_rst;
  logic [1:0]  state;
  logic [2:0]  halt_reason;
  logic        halt_done;
  logic [31:0] cycle_count;
  logic        trace_valid;
  logic [11:0] trace_pc;
  logic [11:0] halt_pc;

  int n_checks = 0;
  int n_fail = 0;

  run_controller dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .breakpoint_en(breakpoint_en), .breakpoint_pc(breakpoint_pc),
    .cycle_limit(cycle_limit), .program_counter(program_counter),
    .instruction(instruction), .execution_enable(execution_enable),
    .core_rst(core_rst), .state(state), .halt_reason(halt_reason),
    .halt_done(halt_done), .cycle_count(cycle_count),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .halt_pc(halt_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op = op;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0;
    breakpoint_en = 1'b0; breakpoint_pc = 12'h0; cycle_limit = 32'd0;
    program_counter = 12'h0; instruction = 16'h1234;
    step(); step();
    rst = 1'b0;
    settle();
    check("reset_state", 32'(state), 32'd0);
    check("reset_exec", 32'(execution_enable), 32'd0);
    check("reset_core_rst", 32'(core_rst), 32'd0);
    check("reset_reason", 32'(halt_reason), 32'd0);
    check("reset_halt_done", 32'(halt_done), 32'd0);
    check("reset_count", cycle_count, 32'd0);
    check("reset_ready", 32'(cmd_ready), 32'd1);

    // Free run for 10 cycles
    send(2'd0);
    for (int i = 0; i < 10; i++) begin
      program_counter = 12'(i);
      settle();
      check($sformatf("run_exec_%0d", i), 32'(execution_enable), 32'd1);
      step();
    end
    check("run_count10", cycle_count, 32'd10);
    check("run_state", 32'(state), 32'd1);

    // Halt instruction at PC 5
    program_counter = 12'h005; instruction = 16'hFFFF;
    settle();
    check("hi_exec_same_cycle", 32'(execution_enable), 32'd0);
    step();
    check("hi_state", 32'(state), 32'd2);
    check("hi_reason", 32'(halt_reason), 32'd1);
    check("hi_halt_done", 32'(halt_done), 32'd1);
    check("hi_count", cycle_count, 32'd10);
    step();
    check("hi_halt_done_pulse", 32'(halt_done), 32'd0);
    instruction = 16'h1234;

    // CLEAR from HALTED: two cycles of core_rst
    send(2'd3);
    check("clr_state1", 32'(state), 32'd3);
    check("clr_core_rst1", 32'(core_rst), 32'd1);
    check("clr_ready1", 32'(cmd_ready), 32'd0);
    step();
    check("clr_core_rst2", 32'(core_rst), 32'd1);
    step();
    check("clr_core_rst_end", 32'(core_rst), 32'd0);
    check("clr_state_idle", 32'(state), 32'd0);
    check("clr_count", cycle_count, 32'd0);

    // Breakpoint at PC 8, then resume past it
    breakpoint_en = 1'b1; breakpoint_pc = 12'h008; program_counter = 12'h006;
    send(2'd0);
    settle();
    check("bp_exec_pc6", 32'(execution_enable), 32'd1);
    step();
    program_counter = 12'h007;
    settle();
    check("bp_exec_pc7", 32'(execution_enable), 32'd1);
    step();
    program_counter = 12'h008;
    settle();
    check("bp_exec_pc8", 32'(execution_enable), 32'd0);
    step();
    check("bp_state", 32'(state), 32'd2);
    check("bp_reason", 32'(halt_reason), 32'd2);
    check("bp_count", cycle_count, 32'd2);
    send(2'd0);
    settle();
    check("resume_exec_pc8", 32'(execution_enable), 32'd1);
    step();
    program_counter = 12'h009;
    settle();
    check("resume_exec_pc9", 32'(execution_enable), 32'd1);
    check("resume_state", 32'(state), 32'd1);
    check("resume_count", cycle_count, 32'd3);
    // Host STOP while running (this cycle still executes)
    send(2'd2);
    check("stop_state", 32'(state), 32'd2);
    check("stop_reason", 32'(halt_reason), 32'd4);
    check("stop_count", cycle_count, 32'd4);
    breakpoint_en = 1'b0;
    send(2'd3); step(); step();
    check("clr2_state", 32'(state), 32'd0);

    // Cycle limit of 4
    cycle_limit = 32'd4;
    send(2'd0);
    for (int i = 0; i < 4; i++) begin
      program_counter = 12'(16 + i);
      settle();
      check($sformatf("lim_exec_%0d", i), 32'(execution_enable), 32'd1);
      step();
    end
    settle();
    check("lim_exec_stop", 32'(execution_enable), 32'd0);
    step();
    check("lim_reason", 32'(halt_reason), 32'd3);
    check("lim_count", cycle_count, 32'd4);
    cycle_limit = 32'd0;
    send(2'd3); step(); step();

    // Three STEPs from IDLE
    for (int i = 0; i < 3; i++) begin
      send(2'd1);
      settle();
      check($sformatf("step_exec_%0d", i), 32'(execution_enable), 32'd1);
      check($sformatf("step_ready_%0d", i), 32'(cmd_ready), 32'd0);
      check($sformatf("step_state_%0d", i), 32'(state), 32'd1);
      step();
      check($sformatf("step_halted_%0d", i), 32'(state), 32'd2);
      check($sformatf("step_reason_%0d", i), 32'(halt_reason), 32'd0);
      check($sformatf("step_count_%0d", i), cycle_count, 32'(i + 1));
    end

    // STEP onto a halt instruction does not execute
    instruction = 16'hFFFF;
    send(2'd1);
    settle();
    check("step_hi_exec", 32'(execution_enable), 32'd0);
    step();
    check("step_hi_reason", 32'(halt_reason), 32'd1);
    check("step_hi_count", cycle_count, 32'd3);
    instruction = 16'h1234;

    // rst during FLUSH
    send(2'd3);
    check("mid_flush_core_rst", 32'(core_rst), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_flush_core_rst", 32'(core_rst), 32'd0);
    check("rst_flush_state", 32'(state), 32'd0);
    check("rst_flush_count", cycle_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
